// File: rtl/fir_pkg.sv
// Shared widths, types and FSM state encoding for the serial FIR block.
// Defaults give a 24-bit, 256-tap moving average.
// The accumulator carries log2(depth) guard bits so the running sum never wraps.
package fir_pkg;

  localparam int DATA_WIDTH_DFLT = 24;
  localparam int FIR_DEPTH_DFLT  = 256;
  localparam int LOG2_DEPTH      = $clog2(FIR_DEPTH_DFLT);
  localparam int ACC_WIDTH       = DATA_WIDTH_DFLT + LOG2_DEPTH;

  typedef logic signed [DATA_WIDTH_DFLT-1:0] sample_t;
  typedef logic signed [ACC_WIDTH-1:0]       acc_t;

  // Shared by the deserializer and the serializer.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/fir_moving_avg.sv
// Moving-average FIR: circular history buffer plus running sum, one sample at a time.
// Latency: 2 cycles from in_vld&in_rdy to out_dat/out_vld.
// Backpressure: in_rdy low while a sample is in flight or the last result is not yet taken.
module fir_moving_avg
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int FIR_DEPTH  = FIR_DEPTH_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  in_rdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_dat
);

  localparam int LOG2_D = $clog2(FIR_DEPTH);
  localparam int ACC_W  = DATA_WIDTH + LOG2_D;

  logic [DATA_WIDTH-1:0] hist_mem [FIR_DEPTH];
  logic [LOG2_D-1:0]     wr_ptr;
  logic                  wrapped;
  logic                  take;

  logic                  s1_vld;
  logic                  s1_old_ok;
  logic [DATA_WIDTH-1:0] s1_new;
  logic [DATA_WIDTH-1:0] s1_old;
  logic [DATA_WIDTH-1:0] old_term;

  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_nxt;

  // One sample in the pipe at a time, and never overwrite an unconsumed result.
  assign in_rdy = en & ~s1_vld & ~out_vld;
  assign take   = in_vld & in_rdy;

  // History RAM: read the oldest sample from the slot about to be overwritten.
  always_ff @(posedge clk) begin
    if (take) begin
      s1_old           <= hist_mem[wr_ptr];
      hist_mem[wr_ptr] <= in_dat;
    end
  end

  // Stage 1: capture the new sample and advance the write pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      wrapped   <= 1'b0;
      s1_vld    <= 1'b0;
      s1_new    <= '0;
      s1_old_ok <= 1'b0;
    end else if (en) begin
      s1_vld <= take;
      if (take) begin
        s1_new    <= in_dat;
        // Slots never written since reset count as zero history.
        s1_old_ok <= wrapped;
        wr_ptr    <= wr_ptr + 1'b1;
        if (wr_ptr == LOG2_D'(FIR_DEPTH - 1)) begin
          wrapped <= 1'b1;
        end
      end
    end
  end

  // Running sum: add the newest sample, drop the one leaving the window.
  always_comb begin
    old_term = s1_old_ok ? s1_old : '0;
    acc_nxt  = acc
             + {{LOG2_D{s1_new[DATA_WIDTH-1]}}, s1_new}
             - {{LOG2_D{old_term[DATA_WIDTH-1]}}, old_term};
  end

  // Stage 2: commit the sum; the top DATA_WIDTH bits are the floor-divided average.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      out_dat <= '0;
      out_vld <= 1'b0;
    end else if (en) begin
      if (s1_vld) begin
        acc     <= acc_nxt;
        out_dat <= acc_nxt[LOG2_D +: DATA_WIDTH];
        out_vld <= 1'b1;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_top_level.sv
// Serial-in / serial-out moving-average FIR (LSB-first words on 1-bit links).
// Latency: fir_din +1 after last input bit, fir_dout +2, o_dout_valid +1 after that.
// Backpressure: sink stalls hold the serializer, then the FIR, then drop o_ready.
module fir_top_level
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int FIR_DEPTH  = FIR_DEPTH_DFLT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_din,
  input  logic i_din_valid,
  input  logic i_ready,
  output logic o_ready,
  output logic o_dout,
  output logic o_dout_valid
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] fir_din;
  logic [DATA_WIDTH-1:0] fir_dout;

  logic                  run_q;
  logic                  din_pend;
  logic                  fir_in_rdy;
  logic                  fir_out_vld;
  logic                  ser_load;

  ser_state_t            des_state;
  logic [CNT_W-1:0]      des_cnt;
  logic [DATA_WIDTH-1:0] des_sr;
  logic                  bit_take;
  logic                  bit_last;

  ser_state_t            ser_state;
  logic [CNT_W-1:0]      ser_cnt;
  logic [DATA_WIDTH-1:0] ser_sr;

  // Input is refused only when a finished word cannot be handed to the FIR.
  assign o_ready  = run_q & i_en & ~(din_pend & ~fir_in_rdy);
  assign bit_take = i_en & i_din_valid & o_ready;
  assign bit_last = (des_state == ST_SHIFT) && (des_cnt == CNT_W'(DATA_WIDTH - 1));

  // o_ready stays low until the first edge after reset is released.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Deserializer: shift bits in LSB first, publish a full word to fir_din.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      des_state <= ST_IDLE;
      des_cnt   <= '0;
      des_sr    <= '0;
      fir_din   <= '0;
      din_pend  <= 1'b0;
    end else if (i_en) begin
      if (din_pend && fir_in_rdy) begin
        din_pend <= 1'b0;
      end
      if (bit_take) begin
        des_sr <= {i_din, des_sr[DATA_WIDTH-1:1]};
        if (bit_last) begin
          fir_din   <= {i_din, des_sr[DATA_WIDTH-1:1]};
          din_pend  <= 1'b1;
          des_cnt   <= '0;
          des_state <= ST_IDLE;
        end else begin
          des_cnt   <= des_cnt + 1'b1;
          des_state <= ST_SHIFT;
        end
      end
    end
  end

  fir_moving_avg #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIR_DEPTH  (FIR_DEPTH)
  ) u_fir (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .en      (i_en),
    .in_vld  (din_pend),
    .in_dat  (fir_din),
    .in_rdy  (fir_in_rdy),
    .out_vld (fir_out_vld),
    .out_rdy (ser_load),
    .out_dat (fir_dout)
  );

  // The serializer only picks up a result while idle, which guarantees the valid gap.
  assign ser_load = i_en & (ser_state == ST_IDLE) & fir_out_vld;
  assign o_dout   = ser_sr[0];

  // Serializer: load fir_dout, shift one bit per accepted handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ser_state    <= ST_IDLE;
      ser_cnt      <= '0;
      ser_sr       <= '0;
      o_dout_valid <= 1'b0;
    end else if (i_en) begin
      case (ser_state)
        ST_IDLE: begin
          if (fir_out_vld) begin
            ser_sr       <= fir_dout;
            ser_cnt      <= '0;
            o_dout_valid <= 1'b1;
            ser_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (i_ready) begin
            ser_sr <= {1'b0, ser_sr[DATA_WIDTH-1:1]};
            if (ser_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              ser_cnt      <= '0;
              o_dout_valid <= 1'b0;
              ser_state    <= ST_IDLE;
            end else begin
              ser_cnt <= ser_cnt + 1'b1;
            end
          end
        end
        default: ser_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_top_level.sv
// Bench for fir_top_level: directed vector table, corner sequences, random stream.
// Expected outputs come from a window-sum model over the samples sent since reset.
// A free-running sink reassembles serial words and checks them against a queue.
module tb_fir_top_level;
  import fir_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 256;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic i_rst, i_en, i_din, i_din_valid, i_ready;
  logic o_ready, o_dout, o_dout_valid;

  fir_top_level #(.DATA_WIDTH(DW), .FIR_DEPTH(DEPTH)) dut (
    .i_clk        (tb_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .i_ready      (i_ready),
    .o_ready      (o_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid)
  );

  typedef struct packed {
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  int            hist[$];
  bit            sink_en;
  bit            sink_rand;
  vec_t          vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Average of the last DEPTH samples (zeros before reset history), floor-rounded.
  function automatic logic [DW-1:0] model_push(input logic [DW-1:0] s);
    longint sum;
    longint q;
    sample_t sv;
    sv = s;
    hist.push_back(int'(sv));
    if (hist.size() > DEPTH) void'(hist.pop_front());
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    q = sum / DEPTH;
    if (sum < 0 && (sum % DEPTH) != 0) q = q - 1;
    return q[DW-1:0];
  endfunction

  // Sink: reassemble LSB-first words, check each and the valid gap after it.
  initial begin : sink
    logic [DW-1:0] sbits;
    int scnt;
    bit drop_chk;
    sbits = '0; scnt = 0; drop_chk = 0; i_ready = 1'b0;
    forever begin
      @(negedge tb_clk); #1;
      if (!i_rst) begin
        scnt = 0; drop_chk = 0; i_ready = 1'b0;
      end else begin
        if (drop_chk) begin
          chk("valid_gap", o_dout_valid, 0);
          drop_chk = 0;
        end
        i_ready = sink_en && o_dout_valid && (!sink_rand || $urandom_range(3) != 0);
        if (i_ready && o_dout_valid && i_en) begin
          sbits[scnt] = o_dout;
          scnt++;
          if (scnt == DW) begin
            scnt = 0;
            drop_chk = 1;
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_word actual=0x%0h required=none", sbits);
            end else begin
              chk("serial_word", sbits, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge tb_clk);
    i_rst = 1'b0; i_din_valid = 1'b0; i_en = 1'b1;
    hist.delete();
    exp_q.delete();
    repeat (2) @(posedge tb_clk);
    #1;
    chk("rst_o_ready", o_ready, 0);
    chk("rst_o_dout_valid", o_dout_valid, 0);
    chk("rst_o_dout", o_dout, 0);
    chk("rst_fir_din", dut.fir_din, 0);
    chk("rst_fir_dout", dut.fir_dout, 0);
    @(negedge tb_clk);
    i_rst = 1'b1;
    #1 chk("rst_release_same_cycle", o_ready, 0);
    @(posedge tb_clk); #1;
    chk("rst_release_ready", o_ready, 1);
  endtask

  // Send nbits of w; optional random gaps / enable drops, or a 3-cycle enable drop before bit en_off.
  task automatic send_word(input logic [DW-1:0] w, input int nbits, input bit gaps, input int en_off);
    for (int b = 0; b < nbits; b++) begin
      bit at_neg;
      int guard;
      at_neg = 0;
      if (gaps && $urandom_range(7) == 0) begin
        @(negedge tb_clk); i_din_valid = 1'b0; i_din = 1'($urandom);
      end
      if (gaps && $urandom_range(15) == 0) begin
        @(negedge tb_clk); i_en = 1'b0; i_din_valid = 1'b1; i_din = ~w[b];
      end
      if (b == en_off) begin
        @(negedge tb_clk); i_en = 1'b0; i_din_valid = 1'b1; i_din = ~w[b];
        repeat (3) begin
          #1 chk("en_low_o_ready", o_ready, 0);
          @(negedge tb_clk);
        end
        at_neg = 1;
      end
      if (!at_neg) @(negedge tb_clk);
      guard = 0;
      forever begin
        i_en = 1'b1; i_din = w[b]; i_din_valid = 1'b1;
        #1;
        if (o_ready) break;
        guard++;
        if (guard > 5000) begin
          bound_fail("send_timeout");
          break;
        end
        @(negedge tb_clk);
      end
    end
    @(posedge tb_clk); #1;
    i_din_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || o_dout_valid) && guard < 4000) begin
      @(posedge tb_clk); #1;
      guard++;
    end
    if (guard >= 4000) bound_fail("drain_timeout");
    repeat (2) @(posedge tb_clk);
    #1;
  endtask

  // FIR unstalled (drained before): fir_dout is valid exactly 2 edges after fir_din.
  task automatic apply_vec(input logic [DW-1:0] din, input logic [DW-1:0] exp,
                           input string tag, input int en_off);
    exp_q.push_back(model_push(din));
    send_word(din, DW, 0, en_off);
    chk({tag, "_fir_din"}, dut.fir_din, din);
    repeat (2) @(posedge tb_clk);
    #1 chk({tag, "_fir_dout"}, dut.fir_dout, exp);
    drain();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [DW-1:0] w;
    logic          held;
    int            guard;
    i_rst = 1'b0; i_en = 1'b1; i_din = 1'b0; i_din_valid = 1'b0;
    sink_en = 1; sink_rand = 0;

    vecs[0] = '{din: 24'h000100, exp: 24'h000001};
    vecs[1] = '{din: 24'h000200, exp: 24'h000003};
    vecs[2] = '{din: 24'hFFFF00, exp: 24'h000002};
    vecs[3] = '{din: 24'h800000, exp: 24'hFF8002};
    vecs[4] = '{din: 24'h0000FF, exp: 24'hFF8002};
    vecs[5] = '{din: 24'h7FFFFF, exp: 24'h000002};
    vecs[6] = '{din: 24'hFFFFFF, exp: 24'h000002};
    vecs[7] = '{din: 24'hFFFC00, exp: 24'hFFFFFE};

    do_reset();

    // Deserializer and exact pipeline timing.
    exp_q.push_back(model_push(24'h5A5A5A));
    send_word(24'h5A5A5A, DW, 0, -1);
    chk("deser_fir_din", dut.fir_din, 24'h5A5A5A);
    @(posedge tb_clk); #1 chk("fir_lat_e1", dut.fir_dout, 0);
    @(posedge tb_clk); #1 chk("fir_lat_e2", dut.fir_dout, 24'h005A5A);
    chk("ser_not_yet_valid", o_dout_valid, 0);
    @(posedge tb_clk); #1 chk("ser_load_valid", o_dout_valid, 1);
    chk("ser_bit0", o_dout, 0);
    drain();

    // Vector table from a clean history.
    do_reset();
    for (int i = 0; i < 8; i++) apply_vec(vecs[i].din, vecs[i].exp, "table", -1);

    // Most negative sample: sign extension and floor.
    do_reset();
    apply_vec(24'h800000, 24'hFF8000, "neg", -1);

    // Ramp through a full window and past the pointer wrap.
    do_reset();
    for (int k = 1; k <= DEPTH + 1; k++)
      apply_vec(24'h000100, 24'(k > DEPTH ? DEPTH : k), "ramp", -1);

    // Enable low mid-word, then enable low mid-serialization.
    do_reset();
    apply_vec(24'h000300, 24'h000003, "en_mid", 10);
    exp_q.push_back(model_push(24'h000500));
    send_word(24'h000500, DW, 0, -1);
    guard = 0;
    while (!o_dout_valid && guard < 100) begin @(posedge tb_clk); #1; guard++; end
    if (guard >= 100) bound_fail("en_ser_wait");
    chk("en_ser_fir_dout", dut.fir_dout, 24'h000008);
    repeat (5) @(posedge tb_clk);
    @(negedge tb_clk); i_en = 1'b0;
    #1 held = o_dout;
    repeat (4) begin
      @(posedge tb_clk); #1;
      chk("en_hold_o_dout", o_dout, held);
      chk("en_hold_valid", o_dout_valid, 1);
      chk("en_hold_o_ready", o_ready, 0);
    end
    @(negedge tb_clk); i_en = 1'b1;
    drain();

    // Back-pressure: sink stalled across three words.
    do_reset();
    sink_en = 0;
    exp_q.push_back(model_push(24'h123456)); send_word(24'h123456, DW, 0, -1);
    exp_q.push_back(model_push(24'hABCDEF)); send_word(24'hABCDEF, DW, 0, -1);
    exp_q.push_back(model_push(24'h00FF00)); send_word(24'h00FF00, DW, 0, -1);
    chk("bp_o_ready_low", o_ready, 0);
    repeat (30) @(posedge tb_clk);
    #1 chk("bp_o_ready_held", o_ready, 0);
    chk("bp_valid_held", o_dout_valid, 1);
    chk("bp_nothing_out", exp_q.size(), 3);
    sink_en = 1;
    drain();

    // Reset in the middle of a word discards it and the history.
    do_reset();
    send_word(24'hFFFFFF, 10, 0, -1);
    do_reset();
    apply_vec(24'h000400, 24'h000004, "post_rst", -1);

    // Random stream with gaps, enable drops and a stuttering sink.
    do_reset();
    sink_rand = 1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(3))
        0: w = 24'h7FFFFF;
        1: w = 24'h800000;
        2: w = 24'($urandom_range(511)) - 24'd256;
        default: w = 24'($urandom);
      endcase
      exp_q.push_back(model_push(w));
      send_word(w, DW, 1, -1);
    end
    drain();
    sink_rand = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
